div_by_sub: RTL and testbench
=============================

# div_by_sub

Unsigned integer divider by repeated subtraction: the inverse of the team's multiply-by-repeated-addition datapath, built on the same start/rdy controller-plus-datapath style. It accepts a dividend and divisor on `start`, subtracts the divisor once per clock until the remainder drops below it, and then presents quotient and remainder with `rdy` high. It is a small, slow, area-cheap arithmetic unit for control paths where throughput does not matter.

## Interface
- `data_width`, default 8: operand, quotient and remainder width; a shared constant from `div_by_sub_pkg`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  request; sampled only while `rdy`=1.
- `N`  in  data_width  dividend, unsigned.
- `D`  in  data_width  divisor, unsigned.
- `rdy`  out  1  idle / result valid.
- `Q`  out  data_width  quotient register.
- `R`  out  data_width  remainder register.
- `dbz`  out  1  divide-by-zero flag; exists only with `DIV_BY_SUB_DBZ_EN`.

## Operation
- Registers: RN (working remainder, drives `R`), RD (divisor), RQ (quotient, drives `Q`), and a 2-state FSM `state_t` {S_idle, S_1}.
- S_idle:
  - `rdy`=1.
  - If `start`=1: RN<=N, RD<=D, RQ<=0, clear `dbz`, go to S_1.
  - Otherwise all registers hold.
- S_1, evaluated in priority order:
  - If RD==0: RQ<=all ones, RN holds N, set `dbz`, go to S_idle.
  - Else if RN<RD: go to S_idle.
  - Else: RN<=RN-RD, RQ<=RQ+1, stay in S_1.
- Arithmetic:
  - Unsigned, data_width bits.
  - RN-RD never underflows because RN>=RD is checked first.
  - RQ never overflows because D>=1 implies the quotient is at most N.
- `start` while busy (`rdy`=0) is ignored; operands are not re-sampled.
- `N` and `D` may change freely after the load edge.
- Invalid or unreachable state: go to S_idle, `rdy`=1.

## Timing
- Reset: state=S_idle, `rdy`=1, `Q`=0, `R`=0, `dbz`=0, RD=0.
  - Reset takes effect immediately.
  - Reset mid-operation aborts the division; no partial result is retained.
- Load edge E0 (S_idle with `start`=1) gives `rdy`=0 from the next cycle.
- D>=1, quotient q:
  - Edges E1..Eq perform the subtractions.
  - Edge E(q+1) returns to S_idle.
  - Busy for exactly q+1 cycles.
- D=0: busy for exactly 1 cycle.
- While busy, `Q`/`R` show intermediate values. They are final from the first cycle `rdy`=1 and hold until the next load edge.
- Back-to-back operation: `start` held high in the first `rdy` cycle loads the next operands on that edge, with no dead cycle.
- Worst case: N=2^data_width-1, D=1 gives 2^data_width cycles.

## Configuration
- `DIV_BY_SUB_DBZ_EN` defined:
  - The `dbz` port and flag register exist.
  - `dbz` is set on the D=0 exit, held while idle, and cleared on the next load edge or by reset.
- Not defined:
  - The `dbz` port and register are absent.
  - D=0 still terminates after 1 busy cycle with `Q`=all ones and `R`=N, so the block never hangs.

## Structure
- `div_by_sub_pkg`: `data_width`, `state_t` enum {S_idle, S_1}.
- Single module; controller (FSM plus control strobes) and datapath live in separate always blocks of the same file. No sub-module.

## Test plan
- Reset, then N=13, D=4, `start` pulse: `rdy` low for 4 cycles, then `Q`=3, `R`=1, `dbz`=0.
- N=5, D=7: busy 1 cycle, `Q`=0, `R`=5. N=0, D=3: busy 1 cycle, `Q`=0, `R`=0.
- N=255, D=1: busy 256 cycles, `Q`=255, `R`=0. N=255, D=255: busy 2 cycles, `Q`=1, `R`=0.
- N=200, D=0: busy 1 cycle, `Q`=255, `R`=200, `dbz`=1 (macro on). The next load with D=0x05 clears `dbz`.
- N=100, D=3: change `N`/`D` and pulse `start` during busy; result is still `Q`=33, `R`=1. Then hold `start` high in the first `rdy` cycle with N=9, D=2: new load with no gap, result `Q`=4, `R`=1.
- Assert `rst` mid-division of 100/3: `rdy`=1, `Q`=0, `R`=0 immediately. A fresh 13/4 then completes correctly.

Source files
------------

// File: rtl/div_by_sub_pkg.sv
// div_by_sub_pkg
// Shared constants and types for the repeated-subtraction divider.
//   data_width : operand / quotient / remainder width
//   state_t    : controller states {S_idle, S_1}
package div_by_sub_pkg;

    localparam int data_width = 8;

    typedef enum logic [0:0] {
        S_idle = 1'b0,
        S_1    = 1'b1
    } state_t;

endpackage

// File: rtl/div_by_sub.sv
// div_by_sub
// Unsigned divider by repeated subtraction. Operands are captured on an
// idle-cycle start, then the divisor is subtracted once per clock until the
// working remainder drops below it. Quotient/remainder are final while rdy=1.
//
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous reset, active-high
//   start in   request, sampled only while rdy=1
//   N     in   dividend (data_width, unsigned)
//   D     in   divisor  (data_width, unsigned)
//   rdy   out  idle / result valid
//   Q     out  quotient register
//   R     out  remainder register
//   dbz   out  divide-by-zero flag (only when DIV_BY_SUB_DBZ_EN is defined)
//
// Build option: DIV_BY_SUB_DBZ_EN adds the dbz port and its flag register.
// Without it, D=0 still exits after one busy cycle with Q=all ones, R=N.
module div_by_sub
    import div_by_sub_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [data_width-1:0] N,
    input  logic [data_width-1:0] D,
    output logic                  rdy,
    output logic [data_width-1:0] Q,
    output logic [data_width-1:0] R
`ifdef DIV_BY_SUB_DBZ_EN
    ,
    output logic                  dbz
`endif
);

    localparam logic [data_width-1:0] ONE = {{(data_width-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [data_width-1:0] rn_q, rn_d;
    logic [data_width-1:0] rd_q, rd_d;
    logic [data_width-1:0] rq_q, rq_d;

    // Control strobes from the controller to the datapath
    logic load;
    logic sub_step;
    logic zero_exit;

    // ---------------- controller ----------------
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        sub_step  = 1'b0;
        zero_exit = 1'b0;
        case (state_q)
            S_idle: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = S_1;
                end
            end
            S_1: begin
                // Zero divisor is tested first so the loop can never spin forever.
                if (rd_q == '0) begin
                    zero_exit = 1'b1;
                    state_d   = S_idle;
                end else if (rn_q < rd_q) begin
                    state_d = S_idle;
                end else begin
                    sub_step = 1'b1;
                end
            end
            default: state_d = S_idle;
        endcase
    end

    // Anything other than the busy state reads as idle.
    assign rdy = (state_q != S_1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_idle;
        else     state_q <= state_d;
    end

    // ---------------- datapath ----------------
    always_comb begin
        rn_d = rn_q;
        rd_d = rd_q;
        rq_d = rq_q;
        if (load) begin
            rn_d = N;
            rd_d = D;
            rq_d = '0;
        end else if (zero_exit) begin
            rq_d = '1;                // remainder keeps the dividend
        end else if (sub_step) begin
            rn_d = rn_q - rd_q;       // safe: rn_q >= rd_q here
            rq_d = rq_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rn_q <= '0;
            rd_q <= '0;
            rq_q <= '0;
        end else begin
            rn_q <= rn_d;
            rd_q <= rd_d;
            rq_q <= rq_d;
        end
    end

    assign Q = rq_q;
    assign R = rn_q;

`ifdef DIV_BY_SUB_DBZ_EN
    logic dbz_q, dbz_d;

    // Set on the zero-divisor exit, held while idle, cleared by the next load.
    always_comb begin
        dbz_d = dbz_q;
        if (load)           dbz_d = 1'b0;
        else if (zero_exit) dbz_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dbz_q <= 1'b0;
        else     dbz_q <= dbz_d;
    end

    assign dbz = dbz_q;
`endif

endmodule

// File: tb/tb_div_by_sub.sv
// tb_div_by_sub
// Directed self-checking bench for div_by_sub. Inputs are driven just after
// the falling edge, outputs are sampled on the falling edge.
module tb_div_by_sub;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] N;
    logic [7:0] D;
    logic       rdy;
    logic [7:0] Q;
    logic [7:0] R;
`ifdef DIV_BY_SUB_DBZ_EN
    logic       dbz;
`endif

    int checks = 0;
    int errors = 0;

    div_by_sub dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .N     (N),
        .D     (D),
        .rdy   (rdy),
        .Q     (Q),
        .R     (R)
`ifdef DIV_BY_SUB_DBZ_EN
        ,
        .dbz   (dbz)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Called just after a falling edge; loads operands on the next rising edge.
    task automatic start_op(input logic [7:0] n, input logic [7:0] d);
        N     = n;
        D     = d;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts falling edges with rdy=0 until rdy returns; bounded.
    task automatic wait_done(output int busy);
        bit done;
        done = 1'b0;
        busy = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rdy) begin
                done = 1'b1;
                break;
            end
            busy++;
        end
        check("done_in_time", {31'd0, done}, 32'd1);
    endtask

    task automatic run(input string tag, input logic [7:0] n, input logic [7:0] d,
                       input int exp_q, input int exp_r, input int exp_busy);
        int b;
        start_op(n, d);
        wait_done(b);
        check({tag, "_busy"}, b, exp_busy);
        check({tag, "_q"}, {24'd0, Q}, exp_q);
        check({tag, "_r"}, {24'd0, R}, exp_r);
`ifdef DIV_BY_SUB_DBZ_EN
        check({tag, "_dbz"}, {31'd0, dbz}, 32'd0);
`endif
    endtask

    initial begin
        int b;
        rst   = 1'b1;
        start = 1'b0;
        N     = '0;
        D     = '0;
        #1;
        check("reset_rdy", {31'd0, rdy}, 32'd1);
        check("reset_q", {24'd0, Q}, 32'd0);
        check("reset_r", {24'd0, R}, 32'd0);
`ifdef DIV_BY_SUB_DBZ_EN
        check("reset_dbz", {31'd0, dbz}, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run("d13_4",    8'd13,  8'd4,   3,   1,   4);
        run("d5_7",     8'd5,   8'd7,   0,   5,   1);
        run("d0_3",     8'd0,   8'd3,   0,   0,   1);
        run("d255_1",   8'd255, 8'd1,   255, 0,   256);
        run("d255_255", 8'd255, 8'd255, 1,   0,   2);

        // Divide by zero
        start_op(8'd200, 8'd0);
        wait_done(b);
        check("dz_busy", b, 1);
        check("dz_q", {24'd0, Q}, 32'd255);
        check("dz_r", {24'd0, R}, 32'd200);
`ifdef DIV_BY_SUB_DBZ_EN
        check("dz_dbz", {31'd0, dbz}, 32'd1);
`endif
        @(negedge clk);
        check("dz_hold_rdy", {31'd0, rdy}, 32'd1);
        check("dz_hold_q", {24'd0, Q}, 32'd255);
`ifdef DIV_BY_SUB_DBZ_EN
        check("dz_hold_dbz", {31'd0, dbz}, 32'd1);
`endif
        start_op(8'd12, 8'd5);
        @(negedge clk);
        check("dz_clr_rdy", {31'd0, rdy}, 32'd0);
`ifdef DIV_BY_SUB_DBZ_EN
        check("dz_clr_dbz", {31'd0, dbz}, 32'd0);
`endif
        wait_done(b);
        check("d12_5_busy", b + 1, 3);
        check("d12_5_q", {24'd0, Q}, 32'd2);
        check("d12_5_r", {24'd0, R}, 32'd2);

        // Busy-time input changes and start pulse are ignored
        start_op(8'd100, 8'd3);
        @(negedge clk);
        N     = 8'd50;
        D     = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(b);
        check("d100_3_busy", b + 2, 34);
        check("d100_3_q", {24'd0, Q}, 32'd33);
        check("d100_3_r", {24'd0, R}, 32'd1);

        // Back-to-back: load in the first rdy cycle
        start_op(8'd9, 8'd2);
        wait_done(b);
        check("b2b_busy", b, 5);
        check("b2b_q", {24'd0, Q}, 32'd4);
        check("b2b_r", {24'd0, R}, 32'd1);

        // Asynchronous reset mid-division
        start_op(8'd100, 8'd3);
        repeat (5) @(negedge clk);
        check("mid_busy", {31'd0, rdy}, 32'd0);
        check("mid_q_partial", {24'd0, Q}, 32'd4);
        rst = 1'b1;
        #1;
        check("mid_rst_rdy", {31'd0, rdy}, 32'd1);
        check("mid_rst_q", {24'd0, Q}, 32'd0);
        check("mid_rst_r", {24'd0, R}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run("post_rst", 8'd13, 8'd4, 3, 1, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
